fb_write_sched: RTL and testbench

Write-port scheduler for the 1280x720 framebuffer. Shares the single framebuffer write port between a CPU write requester and an internal rectangle/span fill engine. Round-robin arbitration when both requesters contend. Sits between the uncore bus interface and the framebuffer write port, in the pixel-clock domain, ahead of the video scan-out path.

---
 rtl/fb_pkg.sv | 37 +++
 rtl/fb_fill_engine.sv | 103 ++++++++++
 rtl/fb_write_sched.sv | 109 ++++++++++
 tb/tb_fb_write_sched.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer write scheduler.
//   FB_WIDTH/FB_HEIGHT/FB_PIXELS : framebuffer geometry (1280x720)
//   FB_ADDR_W / ADDR_W            : pixel address width
//   DATA_W                        : pixel width, {R, G, B}
//   pixel_t                       : packed 24-bit RGB pixel
//   fill_state_t                  : fill engine FSM states
//   fb_addr_inc()                 : address increment modulo FB_PIXELS
package fb_pkg;

  localparam int FB_WIDTH  = 1280;
  localparam int FB_HEIGHT = 720;
  localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;
  localparam int FB_ADDR_W = $clog2(FB_PIXELS);
  localparam int ADDR_W    = FB_ADDR_W;
  localparam int DATA_W    = 24;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fill_state_t;

  // The last pixel is compared explicitly so the counter never relies on
  // a natural 2^ADDR_W rollover (FB_PIXELS is not a power of two).
  function automatic logic [FB_ADDR_W-1:0] fb_addr_inc(input logic [FB_ADDR_W-1:0] a);
    logic [FB_ADDR_W-1:0] last;
    last = FB_ADDR_W'(FB_PIXELS - 1);
    return (a >= last) ? '0 : a + 1'b1;
  endfunction

endpackage

// File: rtl/fb_fill_engine.sv
// Rectangle/span fill engine: writes 'len' copies of 'color' starting at
// 'base', one pixel per granted cycle, wrapping modulo FB_PIXELS.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   vblank       : vertical blank (only used with FB_SCHED_VBLANK_GATE_EN)
//   start        : one-cycle start pulse (ignored while busy)
//   base/len     : first address / pixel count of the fill
//   color        : fill pixel value
//   gnt          : write port granted to the fill this cycle
//   req          : fill wants the write port this cycle
//   busy, done   : not idle / one-cycle completion pulse
//   addr, data   : address/value for the pixel written on a grant
// Macro FB_SCHED_VBLANK_GATE_EN: when defined, requests are raised only
// while vblank=1; otherwise vblank is ignored.
module fb_fill_engine
  import fb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              vblank,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] len,
  input  pixel_t            color,
  input  logic              gnt,
  output logic              req,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] addr,
  output pixel_t            data
);

  fill_state_t       state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [ADDR_W-1:0] remaining_reg, remaining_next;
  pixel_t            color_reg, color_next;

`ifdef FB_SCHED_VBLANK_GATE_EN
  // Stalling is implicit: without a request there is no grant, so RUN
  // holds its address and remaining count.
  assign req = (state_reg == RUN) && vblank;
`else
  logic vblank_unused;
  assign vblank_unused = vblank;
  assign req = (state_reg == RUN);
`endif

  assign busy = (state_reg != IDLE);
  assign done = (state_reg == DONE);
  assign addr = addr_reg;
  assign data = color_reg;

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    remaining_next = remaining_reg;
    color_next     = color_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            state_next = DONE;
          end else begin
            state_next     = RUN;
            addr_next      = base;
            remaining_next = len;
            color_next     = color;
          end
        end
      end
      RUN: begin
        if (gnt) begin
          addr_next      = fb_addr_inc(addr_reg);
          remaining_next = remaining_reg - 1'b1;
          if (remaining_reg == ADDR_W'(1)) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      color_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      remaining_reg <= remaining_next;
      color_reg     <= color_next;
    end
  end

endmodule

// File: rtl/fb_write_sched.sv
// Framebuffer write-port scheduler. Shares the single write port between
// the CPU requester and the internal fill engine with round-robin
// arbitration on contended cycles, and registers the winning write.
// Ports:
//   clk, rst              : pixel clock, synchronous active-high reset
//   vblank                : vertical blank (fill gating, build-dependent)
//   cpu_req/addr/data     : CPU write request, held until cpu_gnt
//   cpu_gnt               : combinational one-cycle accept pulse
//   fill_start/base/len/color : fill command
//   fill_busy, fill_done  : fill status
//   fb_we/addr/data       : registered framebuffer write (1-cycle latency)
// Macro FB_SCHED_VBLANK_GATE_EN: restricts fill writes to vblank=1.
module fb_write_sched
  import fb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              vblank,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic              cpu_gnt,
  input  logic              fill_start,
  input  logic [ADDR_W-1:0] fill_base,
  input  logic [ADDR_W-1:0] fill_len,
  input  logic [DATA_W-1:0] fill_color,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [DATA_W-1:0] fb_data
);

  logic              fill_req;
  logic              fill_gnt;
  logic [ADDR_W-1:0] fill_addr;
  pixel_t            fill_pix;

  fb_fill_engine u_fill (
    .clk    (clk),
    .rst    (rst),
    .vblank (vblank),
    .start  (fill_start),
    .base   (fill_base),
    .len    (fill_len),
    .color  (pixel_t'(fill_color)),
    .gnt    (fill_gnt),
    .req    (fill_req),
    .busy   (fill_busy),
    .done   (fill_done),
    .addr   (fill_addr),
    .data   (fill_pix)
  );

  // fill_prio_reg=1 means the CPU won the last contended cycle, so the
  // fill wins the next one. Reset value 0 favours the CPU.
  logic fill_prio_reg;
  logic contended;
  logic cpu_win;

  assign contended = cpu_req && fill_req;
  assign cpu_win   = cpu_req && (!fill_req || !fill_prio_reg);
  assign cpu_gnt   = cpu_win && !rst;
  assign fill_gnt  = fill_req && !cpu_win && !rst;

  logic              fb_we_reg, fb_we_next;
  logic [ADDR_W-1:0] fb_addr_reg, fb_addr_next;
  logic [DATA_W-1:0] fb_data_reg, fb_data_next;
  logic              cpu_in_range;

  // Out-of-range CPU writes still get their grant but never reach the port.
  assign cpu_in_range = (cpu_addr < ADDR_W'(FB_PIXELS));

  always_comb begin
    fb_we_next   = 1'b0;
    fb_addr_next = fb_addr_reg;
    fb_data_next = fb_data_reg;
    if (cpu_gnt && cpu_in_range) begin
      fb_we_next   = 1'b1;
      fb_addr_next = cpu_addr;
      fb_data_next = cpu_data;
    end else if (fill_gnt) begin
      fb_we_next   = 1'b1;
      fb_addr_next = fill_addr;
      fb_data_next = fill_pix;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_prio_reg <= 1'b0;
      fb_we_reg     <= 1'b0;
      fb_addr_reg   <= '0;
      fb_data_reg   <= '0;
    end else begin
      if (contended) begin
        fill_prio_reg <= cpu_win;
      end
      fb_we_reg   <= fb_we_next;
      fb_addr_reg <= fb_addr_next;
      fb_data_reg <= fb_data_next;
    end
  end

  assign fb_we   = fb_we_reg;
  assign fb_addr = fb_addr_reg;
  assign fb_data = fb_data_reg;

endmodule

// File: tb/tb_fb_write_sched.sv
// Randomized + directed bench for fb_write_sched against a behavioural
// model (integer fill job, "who won the last contention", expected write).
module tb_fb_write_sched;
  import fb_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              vblank = 1'b1;
  logic              cpu_req = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_data = '0;
  logic              cpu_gnt;
  logic              fill_start = 1'b0;
  logic [ADDR_W-1:0] fill_base = '0;
  logic [ADDR_W-1:0] fill_len = '0;
  logic [DATA_W-1:0] fill_color = '0;
  logic              fill_busy;
  logic              fill_done;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic [DATA_W-1:0] fb_data;

  fb_write_sched dut (
    .clk        (clk),
    .rst        (rst),
    .vblank     (vblank),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_data   (cpu_data),
    .cpu_gnt    (cpu_gnt),
    .fill_start (fill_start),
    .fill_base  (fill_base),
    .fill_len   (fill_len),
    .fill_color (fill_color),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // Pending CPU writes: {addr, data}
  logic [ADDR_W+DATA_W-1:0] cpu_q[$];

  // Model state
  bit m_valid = 0;
  bit m_run = 0;            // fill job has pixels left to write
  bit m_done = 0;           // completion pulse due this cycle
  bit m_cpu_won_last = 0;   // CPU won the last contended cycle
  int m_addr = 0;
  int m_left = 0;
  int m_color = 0;
  bit e_we = 0;
  int e_addr = 0;
  int e_data = 0;
  int fill_writes = 0;
  int cpu_writes = 0;

  // One clock cycle: drive inputs, check outputs, advance the model.
  task automatic step(input bit r, input bit fs, input int fb, input int fl,
                      input int fc, input bit vb);
    bit freq, cw, fw, busy_now, new_done;
    rst = r; fill_start = fs; fill_base = ADDR_W'(fb); fill_len = ADDR_W'(fl);
    fill_color = DATA_W'(fc); vblank = vb;
    cpu_req = (cpu_q.size() > 0);
    if (cpu_req) {cpu_addr, cpu_data} = cpu_q[0];
    #1;
`ifdef FB_SCHED_VBLANK_GATE_EN
    freq = m_run && vb;
`else
    freq = m_run;
`endif
    cw = !r && cpu_req && (!freq || !m_cpu_won_last);
    fw = !r && freq && !cw;
    busy_now = m_run || m_done;
    if (m_valid) begin
      check("cpu_gnt", 32'(cpu_gnt), 32'(cw));
      check("fill_busy", 32'(fill_busy), 32'(busy_now));
      check("fill_done", 32'(fill_done), 32'(m_done));
      check("fb_we", 32'(fb_we), 32'(e_we));
      check("fb_addr", 32'(fb_addr), 32'(e_addr));
      check("fb_data", 32'(fb_data), 32'(e_data));
    end
    if (r) begin
      m_run = 0; m_done = 0; m_cpu_won_last = 0;
      e_we = 0; e_addr = 0; e_data = 0; m_valid = 1;
    end else begin
      e_we = 0;
      if (cw && (int'(cpu_addr) < FB_PIXELS)) begin
        e_we = 1; e_addr = int'(cpu_addr); e_data = int'(cpu_data);
        cpu_writes++;
      end
      new_done = 0;
      if (fw) begin
        e_we = 1; e_addr = m_addr; e_data = m_color;
        m_addr = (m_addr + 1) % FB_PIXELS;
        m_left--;
        fill_writes++;
        if (m_left == 0) begin m_run = 0; new_done = 1; end
      end
      if (cpu_req && freq) m_cpu_won_last = cw;
      if (!busy_now && fs) begin
        if (fl == 0) new_done = 1;
        else begin m_run = 1; m_addr = fb; m_left = fl; m_color = fc; end
      end
      m_done = new_done;
    end
    if (cw) void'(cpu_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    int fw0, cw0;
    @(posedge clk); #1;
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    idle(2);

    // Single CPU write
    cpu_q.push_back({ADDR_W'(5), DATA_W'(24'hFF0000)});
    idle(3);

    // Lone fill of 4 pixels
    step(0, 1, 100, 4, 24'h00FF00, 1);
    idle(7);

    // Fill of 6 with 3 CPU writes contending
    step(1, 0, 0, 0, 0, 1);
    fw0 = fill_writes; cw0 = cpu_writes;
    step(0, 1, 200, 6, 24'h0000FF, 1);
    for (int i = 0; i < 3; i++) cpu_q.push_back({ADDR_W'(300 + i), DATA_W'(24'h111111 * (i + 1))});
    idle(12);
    check("mix_fill_cnt", 32'(fill_writes - fw0), 32'd6);
    check("mix_cpu_cnt", 32'(cpu_writes - cw0), 32'd3);

    // Wrap at the end of the framebuffer
    step(0, 1, FB_PIXELS - 2, 4, 24'h123456, 1);
    idle(7);

    // Zero-length fill
    step(0, 1, 50, 0, 24'hABCDEF, 1);
    idle(3);

    // Start during RUN is ignored
    step(0, 1, 400, 8, 24'h0F0F0F, 1);
    idle(2);
    step(0, 1, 900, 3, 24'hF0F0F0, 1);
    idle(10);

    // Reset mid-fill
    step(0, 1, 500, 10, 24'h777777, 1);
    idle(3);
    step(1, 0, 0, 0, 0, 1);
    idle(14);

    // Fill of 8 with vblank low for cycles 2..5
    fw0 = fill_writes;
    step(0, 1, 600, 8, 24'h5A5A5A, 1);
    for (int c = 1; c < 16; c++) step(0, 0, 0, 0, 0, !(c >= 2 && c <= 5));
    check("vb_fill_cnt", 32'(fill_writes - fw0), 32'd8);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bit fs, vb, r;
      int fb, fl;
      if (cpu_q.size() == 0 && $urandom_range(0, 2) == 0) begin
        int a;
        a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(FB_PIXELS, (1 << ADDR_W) - 1))
                                        : int'($urandom_range(0, FB_PIXELS - 1));
        cpu_q.push_back({ADDR_W'(a), DATA_W'($urandom)});
      end
      fs = ($urandom_range(0, 15) == 0);
      fl = $urandom_range(0, 12);
      fb = ($urandom_range(0, 3) == 0) ? FB_PIXELS - int'($urandom_range(1, 6))
                                       : int'($urandom_range(0, FB_PIXELS - 1));
      vb = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 299) == 0);
      step(r, fs, fb, fl, int'($urandom & 32'hFFFFFF), vb);
    end
    idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
